// File: rtl/mmio_timer_responder.sv
// Memory-mapped prescaled 32-bit timer with compare, W1C status flags and level interrupt.
// Reads are registered (one-cycle latency) and return pre-update values.
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Hit,
    output logic        Irq
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  irqen_q, irqen_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           dout_q, dout_d;
    logic                  hit_q, hit_d;
    logic                  irq_q, irq_d;

    logic                  hit;
    reg_sel_e              sel;
    logic                  wr_ctrl, wr_count, wr_compare, wr_status;
    logic                  tick;
    logic                  match_set, ovf_set;
    logic [31:0]           ctrl_rd, status_rd;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, Address[1:0]};

    always_comb begin
        hit        = (Address[31:4] == BASE_ADDR[31:4]);
        sel        = reg_sel_e'(Address[3:2]);
        wr_ctrl    = Wr && hit && (sel == REG_CTRL);
        wr_count   = Wr && hit && (sel == REG_COUNT);
        wr_compare = Wr && hit && (sel == REG_COMPARE);
        wr_status  = Wr && hit && (sel == REG_STATUS);

        ctrl_rd                       = '0;
        ctrl_rd[0]                    = en_q;
        ctrl_rd[1]                    = auto_q;
        ctrl_rd[2]                    = irqen_q;
        ctrl_rd[16 +: PRESCALE_W]     = presc_q;
        status_rd                     = '0;
        status_rd[0]                  = match_q;
        status_rd[1]                  = ovf_q;
        status_rd[16 +: PRESCALE_W]   = pre_q;

        hit_d  = hit;
        dout_d = '0;
        if (hit) begin
            case (sel)
                REG_CTRL:    dout_d = ctrl_rd;
                REG_COUNT:   dout_d = count_q;
                REG_COMPARE: dout_d = compare_q;
                REG_STATUS:  dout_d = status_rd;
                default:     dout_d = '0;
            endcase
        end

        // A CTRL write restarts the prescale period and suppresses this cycle's tick.
        tick  = 1'b0;
        pre_d = pre_q;
        if (wr_ctrl) begin
            pre_d = '0;
        end else if (en_q) begin
            if (pre_q == presc_q) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end

        match_set = 1'b0;
        ovf_set   = 1'b0;
        count_d   = count_q;
        if (wr_count) begin
            count_d = DataIn;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                ovf_set   = (count_q == 32'hFFFF_FFFF) && !auto_q;
                count_d   = auto_q ? '0 : count_q + 32'd1;
            end else if (count_q == 32'hFFFF_FFFF) begin
                ovf_set = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        compare_d = wr_compare ? DataIn : compare_q;

        en_d    = en_q;
        auto_d  = auto_q;
        irqen_d = irqen_q;
        presc_d = presc_q;
        if (wr_ctrl) begin
            en_d    = DataIn[0];
            auto_d  = DataIn[1];
            irqen_d = DataIn[2];
            presc_d = DataIn[16 +: PRESCALE_W];
        end

        // Hardware set wins over a same-cycle W1C clear.
        match_d = (match_q && !(wr_status && DataIn[0])) || match_set;
        ovf_d   = (ovf_q   && !(wr_status && DataIn[1])) || ovf_set;

        irq_d = irqen_q && (match_q || ovf_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            irqen_q   <= 1'b0;
            presc_q   <= '0;
            pre_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            dout_q    <= '0;
            hit_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            irqen_q   <= irqen_d;
            presc_q   <= presc_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            hit_q     <= hit_d;
            irq_q     <= irq_d;
        end
    end

    assign DataOut = dout_q;
    assign Hit     = hit_q;
    assign Irq     = irq_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder: register access, timer sequencing and flag priorities.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam logic [31:0] IDLE = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic        Wr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Hit;
    logic        Irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mmio_timer_responder #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(16)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .Address(Address),
        .Wr     (Wr),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .Hit    (Hit),
        .Irq    (Irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        Wr      = 1'b1;
        DataIn  = d;
        @(posedge clock);
        #1;
        Address = IDLE;
        Wr      = 1'b0;
        DataIn  = '0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        Wr      = 1'b0;
        @(posedge clock);
        #1;
        Address = IDLE;
        chk(tag, DataOut, exp);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [31:0] ar_cnt [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    logic [31:0] ar_irq [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    logic [31:0] ps_st  [6] = '{32'h0, 32'h1_0000, 32'h2_0000, 32'h0, 32'h1_0000, 32'h2_0000};
    logic [31:0] ps_cnt [4] = '{32'd2, 32'd2, 32'd2, 32'd3};

    initial begin
        reset   = 1'b0;
        Address = BASE + 32'h4;
        Wr      = 1'b0;
        DataIn  = '0;
        idle(2);
        chk("por_hit", {31'b0, Hit}, 32'd0);
        chk("por_dout", DataOut, 32'd0);
        chk("por_irq", {31'b0, Irq}, 32'd0);
        reset   = 1'b1;
        Address = IDLE;

        // Run to a match with interrupts on, then reset mid-count.
        bus_write(BASE + 32'h8, 32'd2);
        bus_write(BASE + 32'h0, 32'h0000_0005);
        idle(6);
        chk("pre_rst_irq", {31'b0, Irq}, 32'd1);
        reset   = 1'b0;
        Address = BASE + 32'h4;
        idle(2);
        chk("rst_hit", {31'b0, Hit}, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        chk("rst_irq", {31'b0, Irq}, 32'd0);
        reset   = 1'b1;
        Address = IDLE;
        read_chk("rst_count", BASE + 32'h4, 32'd0);
        read_chk("rst_status", BASE + 32'hC, 32'd0);
        read_chk("rst_ctrl", BASE + 32'h0, 32'd0);
        read_chk("rst_compare", BASE + 32'h8, 32'd0);

        // Read latency and decode.
        bus_write(BASE + 32'h8, 32'h0000_0010);
        read_chk("lat_compare", BASE + 32'h8, 32'h10);
        chk("lat_hit", {31'b0, Hit}, 32'd1);
        read_chk("miss_dout", IDLE, 32'd0);
        chk("miss_hit", {31'b0, Hit}, 32'd0);

        // Compare with auto-reload, PRESCALE=0.
        bus_write(BASE + 32'h8, 32'd3);
        bus_write(BASE + 32'h0, 32'h0000_0007);
        for (int i = 0; i < 6; i++) begin
            read_chk($sformatf("ar_count%0d", i), BASE + 32'h4, ar_cnt[i]);
            chk($sformatf("ar_irq%0d", i), {31'b0, Irq}, ar_irq[i]);
        end
        read_chk("ar_status", BASE + 32'hC, 32'h1);
        bus_write(BASE + 32'h0, 32'h0);
        bus_write(BASE + 32'hC, 32'h1);
        read_chk("w1c_match", BASE + 32'hC, 32'h0);

        // Prescale of 2: tick every third cycle.
        bus_write(BASE + 32'h4, 32'd0);
        bus_write(BASE + 32'h0, 32'h0002_0001);
        for (int i = 0; i < 6; i++)
            read_chk($sformatf("ps_status%0d", i), BASE + 32'hC, ps_st[i]);
        for (int i = 0; i < 4; i++)
            read_chk($sformatf("ps_count%0d", i), BASE + 32'h4, ps_cnt[i]);
        bus_write(BASE + 32'h0, 32'h0);
        bus_write(BASE + 32'hC, 32'h3);

        // Overflow, W1C of OVF, and collisions.
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h8, 32'd5);
        chk("wr_old_compare", DataOut, 32'd3);
        chk("wr_hit", {31'b0, Hit}, 32'd1);
        bus_write(BASE + 32'h0, 32'h0000_0005);
        read_chk("ovf_count_pre", BASE + 32'h4, 32'hFFFF_FFFF);
        chk("ovf_irq_pre", {31'b0, Irq}, 32'd0);
        read_chk("ovf_count_wrap", BASE + 32'h4, 32'd0);
        chk("ovf_irq", {31'b0, Irq}, 32'd1);
        read_chk("ovf_status", BASE + 32'hC, 32'h2);
        bus_write(BASE + 32'hC, 32'h2);
        read_chk("ovf_cleared", BASE + 32'hC, 32'h0);
        chk("ovf_irq_clr", {31'b0, Irq}, 32'd0);
        idle(1);
        bus_write(BASE + 32'hC, 32'h1);
        read_chk("w1c_vs_set", BASE + 32'hC, 32'h1);
        bus_write(BASE + 32'h4, 32'h0000_0100);
        read_chk("wr_vs_tick", BASE + 32'h4, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
